sprite_render_engine: RTL and testbench

- Parametrised successor to the per-level hard-wired erase/draw datapath: one engine serialises erase-then-draw of up to N_CHANNELS sprites onto the VGA pixel port.
- Per-channel geometry comes from ports, not per-instance counters, so every level reuses it.
- Adds transparent-colour skipping, screen-edge clipping and a start/done frame handshake.
- Sits between the level control path and the vga adapter; drives one shared background ROM and one sprite ROM interface.

---
 rtl/sprite_render_pkg.sv | 29 ++
 rtl/box_raster_counter.sv | 47 ++++
 rtl/sprite_render_engine.sv | 218 +++++++++++++++++++++
 tb/tb_sprite_render_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_render_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_render_pkg
// Function : Shared state encoding, screen geometry and background address
//            translation for the sprite render engine.
// Revision : 1.0  initial release
// ============================================================================
package sprite_render_pkg;

   localparam int c_SCREEN_W = 320;
   localparam int c_SCREEN_H = 240;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_ERASE = 3'd2,
      ST_DRAW  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Linear background ROM address; out-of-screen inputs simply wrap.
   function automatic logic [16:0] bg_addr(input logic [9:0] x,
                                           input logic [9:0] y,
                                           input int unsigned width);
      return 17'(17'(y) * 17'(width) + 17'(x));
   endfunction

endpackage
`default_nettype wire

// File: rtl/box_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : box_raster_counter
// Function : Column-inner / row-outer raster over a w x h box with a
//            last-pixel flag; shared by the erase and draw phases.
// Revision : 1.0  initial release
// ============================================================================
module box_raster_counter #(
   parameter int DIM_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIM_W-1:0] i_w,
   input  logic [DIM_W-1:0] i_h,
   output logic [DIM_W-1:0] o_col,
   output logic [DIM_W-1:0] o_row,
   output logic             o_last
);

   logic [DIM_W-1:0] r_col;
   logic [DIM_W-1:0] r_row;
   logic             w_col_end;

   assign w_col_end = (r_col == i_w - DIM_W'(1));

   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_en) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + DIM_W'(1);
         end else begin
            r_col <= r_col + DIM_W'(1);
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_end && (r_row == i_h - DIM_W'(1));

endmodule
`default_nettype wire

// File: rtl/sprite_render_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_render_engine
// Function : Serialises erase-then-draw of up to N_CHANNELS sprites onto the
//            VGA pixel port with transparency skipping and edge clipping.
// Revision : 1.0  initial release
// ============================================================================
module sprite_render_engine
   import sprite_render_pkg::*;
#(
   parameter int                N_CHANNELS  = 4,
   parameter int                COLOR_W     = 3,
   parameter int                SCREEN_W    = c_SCREEN_W,
   parameter int                SCREEN_H    = c_SCREEN_H,
   parameter int                DIM_W       = 7,
   parameter int                SPR_ADDR_W  = 12,
   parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
   parameter bit                TRANSP_EN   = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic [N_CHANNELS-1:0]      ch_req,
   input  logic [9*N_CHANNELS-1:0]    ch_x_old,
   input  logic [9*N_CHANNELS-1:0]    ch_y_old,
   input  logic [9*N_CHANNELS-1:0]    ch_x_new,
   input  logic [9*N_CHANNELS-1:0]    ch_y_new,
   input  logic [DIM_W*N_CHANNELS-1:0] ch_w,
   input  logic [DIM_W*N_CHANNELS-1:0] ch_h,
   output logic [16:0]                bg_address,
   input  logic [COLOR_W-1:0]         bg_color,
   output logic [2:0]                 spr_channel,
   output logic [SPR_ADDR_W-1:0]      spr_address,
   input  logic [COLOR_W-1:0]         spr_color,
   output logic [8:0]                 vga_x,
   output logic [8:0]                 vga_y,
   output logic [COLOR_W-1:0]         vga_c,
   output logic                       plot,
   output logic                       busy,
   output logic                       done
);

   state_t                r_state;
   logic [N_CHANNELS-1:0] r_mask;
   logic [2:0]            r_ch;
   logic                  r_busy;
   logic                  r_done;
   logic [8:0]            r_vx;
   logic [8:0]            r_vy;
   logic                  r_pix_valid;
   logic                  r_in_screen;
   logic                  r_is_draw;

   // Channel fields padded to 8 entries so the 3-bit channel index is exact.
   logic [8:0]       w_xo [8];
   logic [8:0]       w_yo [8];
   logic [8:0]       w_xn [8];
   logic [8:0]       w_yn [8];
   logic [DIM_W-1:0] w_w  [8];
   logic [DIM_W-1:0] w_h  [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_unpack
         if (gi < N_CHANNELS) begin : g_live
            assign w_xo[gi] = ch_x_old[9*gi +: 9];
            assign w_yo[gi] = ch_y_old[9*gi +: 9];
            assign w_xn[gi] = ch_x_new[9*gi +: 9];
            assign w_yn[gi] = ch_y_new[9*gi +: 9];
            assign w_w[gi]  = ch_w[DIM_W*gi +: DIM_W];
            assign w_h[gi]  = ch_h[DIM_W*gi +: DIM_W];
         end else begin : g_pad
            assign w_xo[gi] = '0;
            assign w_yo[gi] = '0;
            assign w_xn[gi] = '0;
            assign w_yn[gi] = '0;
            assign w_w[gi]  = '0;
            assign w_h[gi]  = '0;
         end
      end
   endgenerate

   // Lowest set bit wins.
   logic [2:0]            w_sel;
   logic [N_CHANNELS-1:0] w_sel_bit;
   logic                  w_any;

   always_comb begin
      w_sel     = '0;
      w_sel_bit = '0;
      w_any     = 1'b0;
      for (int i = N_CHANNELS - 1; i >= 0; i--) begin
         if (r_mask[i]) begin
            w_sel        = 3'(i);
            w_sel_bit    = '0;
            w_sel_bit[i] = 1'b1;
            w_any        = 1'b1;
         end
      end
   end

   logic             w_sel_empty;
   logic             w_active;
   logic             w_is_draw;
   logic             w_cnt_load;
   logic [DIM_W-1:0] w_col;
   logic [DIM_W-1:0] w_row;
   logic             w_last;
   logic [8:0]       w_x_base;
   logic [8:0]       w_y_base;
   logic [9:0]       w_x_sum;
   logic [9:0]       w_y_sum;
   logic             w_on_screen;
   logic             w_transp;

   assign w_sel_empty = (w_w[w_sel] == '0) || (w_h[w_sel] == '0);
   assign w_is_draw   = (r_state == ST_DRAW);
   assign w_active    = (r_state == ST_ERASE) || w_is_draw;
   assign w_cnt_load  = (r_state == ST_SCAN) || ((r_state == ST_ERASE) && w_last);

   box_raster_counter #(
      .DIM_W (DIM_W)
   ) u_raster (
      .clk    (clock),
      .rst    (reset),
      .i_load (w_cnt_load),
      .i_en   (w_active),
      .i_w    (w_w[r_ch]),
      .i_h    (w_h[r_ch]),
      .o_col  (w_col),
      .o_row  (w_row),
      .o_last (w_last)
   );

   // 10-bit sums so pixels past the right/bottom edge are detected, not wrapped.
   assign w_x_base    = w_is_draw ? w_xn[r_ch] : w_xo[r_ch];
   assign w_y_base    = w_is_draw ? w_yn[r_ch] : w_yo[r_ch];
   assign w_x_sum     = 10'(w_x_base) + 10'(w_col);
   assign w_y_sum     = 10'(w_y_base) + 10'(w_row);
   assign w_on_screen = (w_x_sum < 10'(SCREEN_W)) && (w_y_sum < 10'(SCREEN_H));

   assign bg_address  = (r_state == ST_ERASE) ? bg_addr(w_x_sum, w_y_sum, SCREEN_W) : '0;
   assign spr_address = w_is_draw ? SPR_ADDR_W'(SPR_ADDR_W'(w_row) * SPR_ADDR_W'(w_w[r_ch])
                                                 + SPR_ADDR_W'(w_col)) : '0;
   assign spr_channel = r_ch;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mask      <= '0;
         r_ch        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_vx        <= '0;
         r_vy        <= '0;
         r_pix_valid <= 1'b0;
         r_in_screen <= 1'b0;
         r_is_draw   <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_vx        <= w_active ? w_x_sum[8:0] : '0;
         r_vy        <= w_active ? w_y_sum[8:0] : '0;
         r_pix_valid <= w_active;
         r_in_screen <= w_active && w_on_screen;
         r_is_draw   <= w_is_draw;
         case (r_state)
            ST_IDLE: begin
               if (frame_start) begin
                  r_mask  <= ch_req;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!w_any) begin
                  // The last pixel leaves the pipeline this cycle.
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_mask <= r_mask & ~w_sel_bit;
                  r_ch   <= w_sel;
                  if (!w_sel_empty) begin
                     r_state <= ST_ERASE;
                  end
               end
            end
            ST_ERASE: begin
               if (w_last) begin
                  r_state <= ST_DRAW;
               end
            end
            ST_DRAW: begin
               if (w_last) begin
                  r_state <= ST_SCAN;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_transp = TRANSP_EN && r_is_draw && (spr_color == TRANSPARENT);

   assign vga_x = r_vx;
   assign vga_y = r_vy;
   assign vga_c = r_pix_valid ? (r_is_draw ? spr_color : bg_color) : '0;
   assign plot  = r_pix_valid && r_in_screen && !w_transp;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_render_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_render_engine
// Function : Directed bench; two engines (transparency on/off) compared each
//            cycle against a frame-level model of the expected pixel stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_render_engine;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [3:0]  ch_req = '0;
   logic [35:0] ch_x_old = '0, ch_y_old = '0, ch_x_new = '0, ch_y_new = '0;
   logic [27:0] ch_w = '0, ch_h = '0;

   logic [16:0] bg_address0, bg_address1;
   logic [2:0]  bg_color0, bg_color1, spr_color0, spr_color1;
   logic [2:0]  spr_channel0, spr_channel1;
   logic [11:0] spr_address0, spr_address1;
   logic [8:0]  vga_x0, vga_x1, vga_y0, vga_y1;
   logic [2:0]  vga_c0, vga_c1;
   logic        plot0, plot1, busy0, busy1, done0, done1;

   sprite_render_engine #(.TRANSP_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .ch_req(ch_req),
      .ch_x_old(ch_x_old), .ch_y_old(ch_y_old), .ch_x_new(ch_x_new), .ch_y_new(ch_y_new),
      .ch_w(ch_w), .ch_h(ch_h), .bg_address(bg_address0), .bg_color(bg_color0),
      .spr_channel(spr_channel0), .spr_address(spr_address0), .spr_color(spr_color0),
      .vga_x(vga_x0), .vga_y(vga_y0), .vga_c(vga_c0), .plot(plot0), .busy(busy0), .done(done0));

   sprite_render_engine #(.TRANSP_EN(1'b0)) dut_nt (
      .clock(clock), .reset(reset), .frame_start(frame_start), .ch_req(ch_req),
      .ch_x_old(ch_x_old), .ch_y_old(ch_y_old), .ch_x_new(ch_x_new), .ch_y_new(ch_y_new),
      .ch_w(ch_w), .ch_h(ch_h), .bg_address(bg_address1), .bg_color(bg_color1),
      .spr_channel(spr_channel1), .spr_address(spr_address1), .spr_color(spr_color1),
      .vga_x(vga_x1), .vga_y(vga_y1), .vga_c(vga_c1), .plot(plot1), .busy(busy1), .done(done1));

   always #5 clock = ~clock;

   // ROM models: one cycle of read latency.
   logic [2:0] spr_mem [64];
   bit         bg_hash = 1'b0;
   int         bg_const = 5;

   function automatic logic [2:0] bg_rom(input logic [16:0] a);
      if (bg_hash) return a[2:0] ^ a[5:3] ^ a[8:6];
      return 3'(bg_const);
   endfunction

   always @(posedge clock) begin
      bg_color0  <= bg_rom(bg_address0);
      bg_color1  <= bg_rom(bg_address1);
      spr_color0 <= spr_mem[spr_address0[5:0]];
      spr_color1 <= spr_mem[spr_address1[5:0]];
   end

   int n_vec = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int j, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, j, act, exp);
      end
   endtask

   int xo[4], yo[4], xn[4], yn[4], ww[4], hh[4];

   task automatic set_geom();
      for (int i = 0; i < 4; i++) begin
         ch_x_old[9*i +: 9] = 9'(xo[i]);
         ch_y_old[9*i +: 9] = 9'(yo[i]);
         ch_x_new[9*i +: 9] = 9'(xn[i]);
         ch_y_new[9*i +: 9] = 9'(yn[i]);
         ch_w[7*i +: 7]     = 7'(ww[i]);
         ch_h[7*i +: 7]     = 7'(hh[i]);
      end
   endtask

   typedef struct {
      bit pix;
      bit draw;
      int x;
      int y;
      int ch;
      int sa;
   } slot_t;

   // Per-frame statistics from the transparency-enabled engine (index 0)
   int n_plot[2];
   int n_done0, done_j, first_j, last_j, bg_at1;
   int first_x, first_y, first_c, last_x, last_y, last_c;

   function automatic bit exp_plot(input slot_t a, input bit transp);
      if (!a.pix || a.x >= 320 || a.y >= 240) return 1'b0;
      if (transp && a.draw && spr_mem[a.sa % 64] == 3'd0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_frame(input logic [3:0] req, input int inject_j);
      slot_t q[$];
      slot_t s, a;
      int L;
      int pl[2], px[2], py[2], pc[2], bz[2], dn[2], sc[2], sa[2], ba[2];
      int ec;
      for (int c = 0; c < 4; c++) begin
         if (req[c]) begin
            s = '{0, 0, 0, 0, c, 0};
            q.push_back(s);
            if (ww[c] != 0 && hh[c] != 0) begin
               for (int r = 0; r < hh[c]; r++)
                  for (int k = 0; k < ww[c]; k++) q.push_back('{1, 0, xo[c]+k, yo[c]+r, c, 0});
               for (int r = 0; r < hh[c]; r++)
                  for (int k = 0; k < ww[c]; k++)
                     q.push_back('{1, 1, xn[c]+k, yn[c]+r, c, (r*ww[c]+k) % 4096});
            end
         end
      end
      q.push_back('{0, 0, 0, 0, 0, 0});
      L = q.size();
      n_plot = '{0, 0};
      n_done0 = 0; done_j = -1; first_j = -1; last_j = -1; bg_at1 = -1;
      ch_req = req;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      ch_req = 4'b1111;
      for (int j = 0; j <= L + 2; j++) begin
         pl = '{int'(plot0), int'(plot1)};
         px = '{int'(vga_x0), int'(vga_x1)};
         py = '{int'(vga_y0), int'(vga_y1)};
         pc = '{int'(vga_c0), int'(vga_c1)};
         bz = '{int'(busy0), int'(busy1)};
         dn = '{int'(done0), int'(done1)};
         sc = '{int'(spr_channel0), int'(spr_channel1)};
         sa = '{int'(spr_address0), int'(spr_address1)};
         ba = '{int'(bg_address0), int'(bg_address1)};
         if (j >= 1 && j - 1 < L) a = q[j-1];
         else a = '{0, 0, 0, 0, 0, 0};
         for (int d = 0; d < 2; d++) begin
            chk("busy", j, bz[d], int'(j < L));
            chk("done", j, dn[d], int'(j == L));
            chk("plot", j, pl[d], int'(exp_plot(a, d == 0)));
            if (exp_plot(a, d == 0)) begin
               ec = a.draw ? int'(spr_mem[a.sa % 64]) : int'(bg_rom(17'(a.y*320 + a.x)));
               chk("pixel_xyc", j, px[d]*100000 + py[d]*10 + pc[d], a.x*100000 + a.y*10 + ec);
            end
            if (j < L && q[j].pix) begin
               chk("spr_channel", j, sc[d], q[j].ch);
               if (q[j].draw) chk("spr_address", j, sa[d], q[j].sa);
               else if (q[j].x < 320 && q[j].y < 240) chk("bg_address", j, ba[d], q[j].y*320 + q[j].x);
            end
            if (pl[d] != 0) n_plot[d]++;
         end
         if (j == 1) bg_at1 = ba[0];
         if (plot0) begin
            if (first_j < 0) begin
               first_j = j; first_x = px[0]; first_y = py[0]; first_c = pc[0];
            end
            last_j = j; last_x = px[0]; last_y = py[0]; last_c = pc[0];
         end
         if (done0) begin
            n_done0++;
            done_j = j;
         end
         if (j == inject_j) frame_start = 1'b1;
         if (j == inject_j + 1) frame_start = 1'b0;
         @(negedge clock);
      end
      frame_start = 1'b0;
   endtask

   task automatic chk_idle_zero(input string name);
      chk({name, "_outs0"}, 0, int'(|{bg_address0, spr_address0, spr_channel0, vga_x0, vga_y0, vga_c0, plot0}), 0);
      chk({name, "_outs1"}, 0, int'(|{bg_address1, spr_address1, spr_channel1, vga_x1, vga_y1, vga_c1, plot1}), 0);
      chk({name, "_busy"}, 0, int'(busy0 | busy1), 0);
      chk({name, "_done"}, 0, int'(done0 | done1), 0);
   endtask

   task automatic setup_basic();
      bg_hash = 1'b0; bg_const = 5;
      for (int i = 0; i < 64; i++) spr_mem[i] = 3'd6;
      for (int i = 0; i < 4; i++) begin
         xo[i] = 60 + 20*i; yo[i] = 70; xn[i] = 61 + 20*i; yn[i] = 71; ww[i] = 3; hh[i] = 3;
      end
      xo[0] = 10; yo[0] = 20; xn[0] = 11; yn[0] = 20; ww[0] = 2; hh[0] = 2;
      set_geom();
   endtask

   initial begin
      setup_basic();
      repeat (3) @(negedge clock);
      chk_idle_zero("reset_state");
      reset = 1'b0;
      @(negedge clock);

      // Single channel 0, 2x2
      run_frame(4'b0001, -10);
      chk("t1_plots", 0, n_plot[0], 8);
      chk("t1_first_cycle", 0, first_j, 2);
      chk("t1_first_addr", 0, bg_at1, 6410);
      chk("t1_first_pixel", 0, first_x*100000 + first_y*10 + first_c, 10*100000 + 20*10 + 5);
      chk("t1_last_pixel", 0, last_x*100000 + last_y*10 + last_c, 12*100000 + 21*10 + 6);
      chk("t1_done_after_last", 0, done_j - last_j, 1);
      chk("t1_done_cycle", 0, done_j, 10);

      // Channels 1 and 3 only
      bg_hash = 1'b1;
      xo[1] = 50; yo[1] = 60; xn[1] = 52; yn[1] = 61; ww[1] = 3; hh[1] = 2;
      xo[3] = 100; yo[3] = 100; xn[3] = 100; yn[3] = 102; ww[3] = 2; hh[3] = 1;
      set_geom();
      run_frame(4'b1010, -10);
      chk("t2_plots", 0, n_plot[0], 16);
      chk("t2_done_cycle", 0, done_j, 19);

      // Transparency on a 4x1 sprite
      setup_basic();
      spr_mem[0] = 3'd0; spr_mem[1] = 3'd0; spr_mem[2] = 3'd0;
      xo[0] = 30; yo[0] = 30; xn[0] = 40; yn[0] = 30; ww[0] = 4; hh[0] = 1;
      set_geom();
      run_frame(4'b0001, -10);
      chk("t3_plots_transp", 0, n_plot[0], 5);
      chk("t3_plots_opaque", 0, n_plot[1], 8);
      chk("t3_last_pixel", 0, last_x*100000 + last_y*10 + last_c, 43*100000 + 30*10 + 6);

      // Clipping at the bottom-right corner
      setup_basic();
      xo[0] = 5; yo[0] = 5; xn[0] = 318; yn[0] = 239; ww[0] = 4; hh[0] = 2;
      set_geom();
      run_frame(4'b0001, -10);
      chk("t4_plots", 0, n_plot[0], 10);
      chk("t4_last_pixel", 0, last_x*100000 + last_y*10 + last_c, 319*100000 + 239*10 + 6);

      // Zero-width channel 0 skipped; frame_start mid-pass ignored
      setup_basic();
      ww[0] = 0; hh[0] = 3;
      xo[1] = 7; yo[1] = 8; xn[1] = 9; yn[1] = 8; ww[1] = 1; hh[1] = 2;
      set_geom();
      run_frame(4'b0011, 3);
      chk("t5_plots", 0, n_plot[0], 4);
      chk("t5_done_pulses", 0, n_done0, 1);
      chk("t5_done_cycle", 0, done_j, 7);

      // Reset during ERASE
      setup_basic();
      ww[0] = 3; hh[0] = 3; xo[0] = 20; yo[0] = 20;
      set_geom();
      ch_req = 4'b0001;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      @(negedge clock);
      chk("t6_in_erase_plot", 1, int'(plot0), 0);
      @(negedge clock);
      chk("t6_erase_plot", 2, int'(plot0), 1);
      reset = 1'b1;
      @(negedge clock);
      chk_idle_zero("t6_after_reset");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("t6_quiet", k, int'(done0 | busy0 | plot0 | done1 | busy1 | plot1), 0);
      end
      setup_basic();
      run_frame(4'b0001, -10);
      chk("t6_restart_plots", 0, n_plot[0], 8);
      chk("t6_restart_done", 0, done_j, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
